audio_freq_meter: RTL and testbench

Measures the fundamental frequency of an incoming audio sample stream and produces a rising-crossing count per gate window, plus an optional period in clocks. It is the receive-side counterpart of the synth channel: the channel turns a frequency word into samples, and this block turns samples (microphone or a looped-back synth channel) back into a frequency figure for LEDs or the seven-segment display. It sits between the mic/sample source and the display logic in lab tops.

---
 rtl/audio_freq_meter.sv | 153 +++++++++++++++
 tb/tb_audio_freq_meter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_freq_meter.sv
// audio_freq_meter: hysteresis comparator feeding a gated rising-crossing
// counter, for turning an audio sample stream back into a frequency figure.
// Optional period-in-clocks measurement is compiled in when the macro
// AUDIO_FREQ_METER_PERIOD_EN is defined; otherwise period_o/period_vld_o are 0.
module audio_freq_meter #(
    parameter int W_SAMPLE    = 24,
    parameter int HYST        = 256,
    parameter int GATE_CYCLES = 50_000_000,
    parameter int W_FREQ      = 16,
    parameter int W_PERIOD    = 24
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic signed [W_SAMPLE-1:0] sample_i,
    input  logic                       sample_vld_i,
    output logic        [W_FREQ-1:0]   freq_o,
    output logic                       freq_vld_o,
    output logic                       overflow_o,
    output logic        [W_PERIOD-1:0] period_o,
    output logic                       period_vld_o,
    output logic                       level_o
);
    localparam int W_GATE = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [W_GATE-1:0] GATE_LAST = W_GATE'(GATE_CYCLES - 1);
    // Thresholds carry one extra bit so +/-HYST is representable at any sample width.
    localparam logic signed [W_SAMPLE:0] HYST_POS = (W_SAMPLE + 1)'(HYST);
    localparam logic signed [W_SAMPLE:0] HYST_NEG = -HYST_POS;

    localparam logic [0:0] ST_LOW  = 1'b0;
    localparam logic [0:0] ST_HIGH = 1'b1;

    // Saturating increment of the crossing count.
    function automatic logic [W_FREQ-1:0] sat_inc_freq(input logic [W_FREQ-1:0] v);
        return (&v) ? v : v + W_FREQ'(1);
    endfunction

    logic        [0:0]          r_state;
    logic        [W_GATE-1:0]   r_gate;
    logic        [W_FREQ-1:0]   r_cnt;
    logic                       r_ovf;
    logic        [W_FREQ-1:0]   r_freq;
    logic                       r_freq_vld;
    logic                       r_ovf_out;

    logic signed [W_SAMPLE:0]   w_sample_x;
    logic                       w_rise;
    logic                       w_fall;
    logic                       w_term;
    logic        [W_FREQ-1:0]   w_cnt_next;
    logic                       w_ovf_next;

    assign w_sample_x = $signed({sample_i[W_SAMPLE-1], sample_i});
    assign w_rise     = en_i & sample_vld_i & (r_state == ST_LOW)  & (w_sample_x > HYST_POS);
    assign w_fall     = en_i & sample_vld_i & (r_state == ST_HIGH) & (w_sample_x < HYST_NEG);
    assign w_term     = en_i & (r_gate == GATE_LAST);
    // A rise on the terminal cycle still belongs to the ending window.
    assign w_cnt_next = w_rise ? sat_inc_freq(r_cnt) : r_cnt;
    // Overflow means a crossing arrived while the count was already pinned at max.
    assign w_ovf_next = r_ovf | (w_rise & (&r_cnt));

    // Comparator FSM: LOW/HIGH with hysteresis, forced LOW while disabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_LOW;
        end else if (!en_i) begin
            r_state <= ST_LOW;
        end else if (w_rise) begin
            r_state <= ST_HIGH;
        end else if (w_fall) begin
            r_state <= ST_LOW;
        end
    end

    // Gate window counter, per-window crossing count and result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gate     <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_freq     <= '0;
            r_freq_vld <= 1'b0;
            r_ovf_out  <= 1'b0;
        end else begin
            r_freq_vld <= 1'b0;
            if (!en_i) begin
                r_gate <= '0;
                r_cnt  <= '0;
                r_ovf  <= 1'b0;
            end else if (w_term) begin
                r_gate     <= '0;
                r_cnt      <= '0;
                r_ovf      <= 1'b0;
                r_freq     <= w_cnt_next;
                r_ovf_out  <= w_ovf_next;
                r_freq_vld <= 1'b1;
            end else begin
                r_gate <= r_gate + W_GATE'(1);
                r_cnt  <= w_cnt_next;
                r_ovf  <= w_ovf_next;
            end
        end
    end

    assign level_o    = (r_state == ST_HIGH);
    assign freq_o     = r_freq;
    assign freq_vld_o = r_freq_vld;
    assign overflow_o = r_ovf_out;

`ifdef AUDIO_FREQ_METER_PERIOD_EN
    // Saturating increment of the period counter.
    function automatic logic [W_PERIOD-1:0] sat_inc_per(input logic [W_PERIOD-1:0] v);
        return (&v) ? v : v + W_PERIOD'(1);
    endfunction

    logic [W_PERIOD-1:0] r_per_cnt;
    logic [W_PERIOD-1:0] r_period;
    logic                r_period_vld;
    logic                r_armed;

    // Period counter: restarts at 1 on each rise; the first rise only arms it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_per_cnt    <= '0;
            r_period     <= '0;
            r_period_vld <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_period_vld <= 1'b0;
            if (!en_i) begin
                r_per_cnt <= '0;
                r_armed   <= 1'b0;
            end else if (w_rise) begin
                r_per_cnt <= W_PERIOD'(1);
                r_armed   <= 1'b1;
                if (r_armed) begin
                    r_period     <= r_per_cnt;
                    r_period_vld <= 1'b1;
                end
            end else begin
                r_per_cnt <= sat_inc_per(r_per_cnt);
            end
        end
    end

    assign period_o     = r_period;
    assign period_vld_o = r_period_vld;
`else
    assign period_o     = '0;
    assign period_vld_o = 1'b0;
`endif

endmodule

// File: tb/tb_audio_freq_meter.sv
// Testbench for audio_freq_meter: directed stimulus, a cycle-level model of
// the measurement rules, per-cycle output comparison and literal spot checks.
// Honours AUDIO_FREQ_METER_PERIOD_EN the same way the design does.
module tb_audio_freq_meter;
    localparam int W_SAMPLE = 24;
    localparam int HYST     = 256;
    localparam int GATE     = 1000;
    localparam int W_FREQ   = 4;
    localparam int W_PERIOD = 8;
    localparam int FMAX     = (1 << W_FREQ) - 1;
    localparam int PMAX     = (1 << W_PERIOD) - 1;

    logic                       clk = 1'b0;
    logic                       rst_i = 1'b0;
    logic                       en_i = 1'b0;
    logic signed [W_SAMPLE-1:0] sample_i = '0;
    logic                       sample_vld_i = 1'b0;
    logic        [W_FREQ-1:0]   freq_o;
    logic                       freq_vld_o;
    logic                       overflow_o;
    logic        [W_PERIOD-1:0] period_o;
    logic                       period_vld_o;
    logic                       level_o;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    audio_freq_meter #(
        .W_SAMPLE(W_SAMPLE), .HYST(HYST), .GATE_CYCLES(GATE),
        .W_FREQ(W_FREQ), .W_PERIOD(W_PERIOD)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
        .sample_i(sample_i), .sample_vld_i(sample_vld_i),
        .freq_o(freq_o), .freq_vld_o(freq_vld_o), .overflow_o(overflow_o),
        .period_o(period_o), .period_vld_o(period_vld_o), .level_o(level_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: positions are counted in enabled cycles since restart.
    int m_level, m_pos, m_edges, m_armed, m_last, s, rise;
    int e_freq, e_ovf, e_fv, e_period, e_pv;

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            m_level = 0; m_pos = 0; m_edges = 0; m_armed = 0; m_last = 0;
            e_freq = 0; e_ovf = 0; e_fv = 0; e_period = 0; e_pv = 0;
        end else begin
            e_fv = 0;
            e_pv = 0;
            if (!en_i) begin
                m_level = 0; m_pos = 0; m_edges = 0; m_armed = 0;
            end else begin
                rise = 0;
                s = int'(sample_i);
                if (sample_vld_i) begin
                    if (m_level == 0 && s > HYST) begin
                        m_level = 1;
                        rise = 1;
                    end else if (m_level == 1 && s < -HYST) begin
                        m_level = 0;
                    end
                end
                if (rise != 0) begin
                    m_edges++;
`ifdef AUDIO_FREQ_METER_PERIOD_EN
                    if (m_armed != 0) begin
                        e_period = (m_pos - m_last > PMAX) ? PMAX : m_pos - m_last;
                        e_pv = 1;
                    end
`endif
                    m_armed = 1;
                    m_last = m_pos;
                end
                if (m_pos % GATE == GATE - 1) begin
                    e_freq = (m_edges > FMAX) ? FMAX : m_edges;
                    e_ovf  = (m_edges > FMAX) ? 1 : 0;
                    e_fv   = 1;
                    m_edges = 0;
                end
                m_pos++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("freq_o", freq_o, e_freq);
            check("freq_vld_o", freq_vld_o, e_fv);
            check("overflow_o", overflow_o, e_ovf);
            check("period_o", period_o, e_period);
            check("period_vld_o", period_vld_o, e_pv);
            check("level_o", level_o, m_level);
        end
    end

    // Inputs change 2 time units after the active edge, then wait for the next edge.
    task automatic drive(input int smp, input bit vld);
        sample_i = W_SAMPLE'(smp);
        sample_vld_i = vld;
        @(posedge clk);
        #2;
    endtask

    // Square wave starting low; index i picks the phase so waves can be resumed.
    task automatic square(input int amp, input int half, input int start, input int n);
        for (int i = start; i < start + n; i++)
            drive(((i / half) % 2 == 0) ? -amp : amp, 1'b1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        en_i = 1'b0;
        sample_i = '0;
        sample_vld_i = 1'b0;
        @(posedge clk);
        #2;
        rst_i = 1'b0;
        en_i = 1'b1;
    endtask

    task automatic exp_period(input string nm, input int v);
`ifdef AUDIO_FREQ_METER_PERIOD_EN
        check(nm, period_o, v);
`else
        check(nm, period_o, 0);
`endif
    endtask

    initial begin
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #2;
        chk_on = 1'b1;
        check("reset_freq", freq_o, 0);
        check("reset_level", level_o, 0);
        check("reset_period", period_o, 0);

        // Square wave +/-1000, period 100: ten crossings per window.
        do_reset();
        square(1000, 50, 0, 1000);
        check("sq_vld_first", freq_vld_o, 1);
        check("sq_freq1", freq_o, 10);
        check("mdl_sq_freq1", e_freq, 10);
        square(1000, 50, 1000, 1000);
        check("sq_freq2", freq_o, 10);
        check("sq_ovf", overflow_o, 0);
        exp_period("sq_period", 100);

        // Amplitude inside hysteresis: nothing detected.
        do_reset();
        square(200, 50, 0, 1000);
        check("small_vld", freq_vld_o, 1);
        check("small_freq", freq_o, 0);
        check("small_level", level_o, 0);
        exp_period("small_period", 0);

        // Threshold boundaries and invalid samples.
        do_reset();
        for (int i = 0; i < 5; i++) drive(256, 1'b1);
        check("eq_pos_level", level_o, 0);
        for (int i = 0; i < 5; i++) drive(-256, 1'b1);
        for (int i = 0; i < 5; i++) drive(5000, 1'b0);
        check("novld_level", level_o, 0);
        drive(257, 1'b1);
        check("p257_level", level_o, 1);
        drive(-257, 1'b0);
        check("novld_hold_high", level_o, 1);
        drive(-257, 1'b1);
        check("n257_level", level_o, 0);
        for (int i = 0; i < 982; i++) drive(0, 1'b1);
        check("thr_vld", freq_vld_o, 1);
        check("thr_freq", freq_o, 1);

        // Saturation: 50 crossings into a 4-bit count, then a quiet window.
        do_reset();
        square(1000, 10, 0, 1000);
        check("sat_freq", freq_o, 15);
        check("sat_ovf", overflow_o, 1);
        check("mdl_sat_ovf", e_ovf, 1);
        square(1000, 100, 0, 1000);
        check("post_sat_freq", freq_o, 5);
        check("post_sat_ovf", overflow_o, 0);
        exp_period("post_sat_period", 200);

        // Crossing on the terminal cycle, plus period counter saturation.
        do_reset();
        for (int i = 0; i < 500; i++) drive(-1000, 1'b1);
        drive(1000, 1'b1);
        for (int i = 0; i < 498; i++) drive(-1000, 1'b1);
        drive(1000, 1'b1);
        check("term_freq", freq_o, 2);
        check("term_vld", freq_vld_o, 1);
        exp_period("term_period_sat", PMAX);
        for (int i = 0; i < 1000; i++) drive(1000, 1'b1);
        check("after_term_freq", freq_o, 0);
        check("after_term_vld", freq_vld_o, 1);

        // Asynchronous reset mid-window, then restart.
        do_reset();
        square(1000, 50, 0, 1500);
        check("pre_rst_freq", freq_o, 10);
        rst_i = 1'b1;
        #1;
        check("async_rst_freq", freq_o, 0);
        check("async_rst_level", level_o, 0);
        @(posedge clk);
        #2;
        rst_i = 1'b0;
        square(1000, 50, 0, 999);
        check("rst_no_early_vld", freq_vld_o, 0);
        square(1000, 50, 999, 1);
        check("rst_vld", freq_vld_o, 1);
        check("rst_freq", freq_o, 10);

        // Enable low for three cycles mid-window: outputs hold.
        square(1000, 50, 0, 500);
        en_i = 1'b0;
        for (int i = 0; i < 3; i++) drive(1000, 1'b1);
        check("en_hold_freq", freq_o, 10);
        check("en_low_level", level_o, 0);
        en_i = 1'b1;
        square(1000, 50, 0, 999);
        check("en_no_early_vld", freq_vld_o, 0);
        square(1000, 50, 999, 1);
        check("en_vld", freq_vld_o, 1);
        check("en_freq", freq_o, 10);

        drive(0, 1'b0);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
